// File: rtl/vtc_pkg.sv
// Shared types and constants for the video timing mode controller.
// Holds the timing parameter struct, the 4-entry mode table, the FSM state
// encoding and the mode index constants used by vtc_mode_ctrl and vtc_mode_rom.
package vtc_pkg;

  // One complete timing parameter set; every entry obeys
  // total = sync + bp + act + fp on both axes.
  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] h_act;
    logic [11:0] h_fp;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
    logic [11:0] v_act;
    logic [11:0] v_fp;
  } vtc_timing_t;

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,  // generator held in reset for the settle window
    S_SYNC     = 2'd1,  // generator released, waiting for its first VS
    S_RUN      = 2'd2,  // locked, accepting mode requests
    S_WAIT_EOF = 2'd3   // change pending, waiting for the frame boundary
  } vtc_state_t;

  localparam logic [1:0] MODE_640X480   = 2'd0;
  localparam logic [1:0] MODE_800X600   = 2'd1;
  localparam logic [1:0] MODE_1280X720  = 2'd2;
  localparam logic [1:0] MODE_1920X1080 = 2'd3;

  localparam vtc_timing_t TIMING_640X480 = '{
    h_total: 12'd800,  h_sync: 12'd96,  h_bp: 12'd48,  h_act: 12'd640,  h_fp: 12'd16,
    v_total: 12'd525,  v_sync: 12'd2,   v_bp: 12'd33,  v_act: 12'd480,  v_fp: 12'd10};

  localparam vtc_timing_t TIMING_800X600 = '{
    h_total: 12'd1056, h_sync: 12'd128, h_bp: 12'd88,  h_act: 12'd800,  h_fp: 12'd40,
    v_total: 12'd628,  v_sync: 12'd4,   v_bp: 12'd23,  v_act: 12'd600,  v_fp: 12'd1};

  localparam vtc_timing_t TIMING_1280X720 = '{
    h_total: 12'd1650, h_sync: 12'd40,  h_bp: 12'd220, h_act: 12'd1280, h_fp: 12'd110,
    v_total: 12'd750,  v_sync: 12'd5,   v_bp: 12'd20,  v_act: 12'd720,  v_fp: 12'd5};

  localparam vtc_timing_t TIMING_1920X1080 = '{
    h_total: 12'd2200, h_sync: 12'd44,  h_bp: 12'd148, h_act: 12'd1920, h_fp: 12'd88,
    v_total: 12'd1125, v_sync: 12'd5,   v_bp: 12'd36,  v_act: 12'd1080, v_fp: 12'd4};

  // Index 0 is the rightmost element.
  localparam vtc_timing_t [3:0] MODE_TABLE = {
    TIMING_1920X1080, TIMING_1280X720, TIMING_800X600, TIMING_640X480};

  function automatic vtc_timing_t mode_timing(input logic [1:0] idx);
    return MODE_TABLE[idx];
  endfunction

endpackage

// File: rtl/vtc_mode_rom.sv
// Combinational mode table lookup: mode index -> timing parameter set.
// Ports: idx (2-bit mode index) in, timing (vtc_timing_t) out.
// Zero latency, no state; the table covers all four 2-bit indices.
module vtc_mode_rom
  import vtc_pkg::*;
(
  input  logic [1:0]  idx,
  output vtc_timing_t timing
);

  assign timing = mode_timing(idx);

endmodule

// File: rtl/vtc_mode_ctrl.sv
// Run-time mode controller for the video sync/timing generator. Accepts mode
// requests (valid/ready), applies them at the next VS rise, holds the generator
// in reset for SETTLE_CYC cycles, then releases it and reports lock on its first VS.
// Ports: clk/rstn; mode_req_valid/sel/ready request handshake; vs_in from the
// generator; vtg_rstn and h_*/v_* timing to the generator; cur_mode, locked, err_pulse status.
// Optional: define VTC_VS_WDOG_EN to add a VS watchdog (WDOG_CYC) that re-applies
// the current mode when VS goes missing.
module vtc_mode_ctrl
  import vtc_pkg::*;
#(
  parameter int NUM_MODES    = 4,
  parameter int DEFAULT_MODE = 0,
  parameter int X_BITS       = 12,
  parameter int Y_BITS       = 12,
  parameter int SETTLE_CYC   = 16,
  parameter int WDOG_CYC     = 2000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mode_req_valid,
  input  logic [1:0]        mode_req_sel,
  output logic              mode_req_ready,
  input  logic              vs_in,
  output logic              vtg_rstn,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_sync,
  output logic [X_BITS-1:0] h_bp,
  output logic [X_BITS-1:0] h_act,
  output logic [X_BITS-1:0] h_fp,
  output logic [Y_BITS-1:0] v_total,
  output logic [Y_BITS-1:0] v_sync,
  output logic [Y_BITS-1:0] v_bp,
  output logic [Y_BITS-1:0] v_act,
  output logic [Y_BITS-1:0] v_fp,
  output logic [1:0]        cur_mode,
  output logic              locked,
  output logic              err_pulse
);

  localparam int          CW          = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [2:0]  NUM_MODES_L = 3'(NUM_MODES);
  localparam logic [1:0]  DEF_MODE_L  = 2'(DEFAULT_MODE);

  vtc_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          vtg_rstn_nxt, locked_nxt, err_nxt;
  logic [1:0]    cur_mode_nxt, pending, pending_nxt;
  vtc_timing_t   timing, timing_nxt, rom_timing;
  logic          vs_d, vs_rise, req_fire, req_bad, load_timing, wdog_trip;

  vtc_mode_rom u_rom (
    .idx    (pending),
    .timing (rom_timing)
  );

  // vs_d is held low while the generator is in reset so the first VS after
  // release is always seen as a rising edge, even if VS comes up high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vs_d <= 1'b0;
    else       vs_d <= vtg_rstn ? vs_in : 1'b0;
  end

  assign vs_rise        = vs_in & ~vs_d;
  assign mode_req_ready = (state == S_RUN);
  assign req_fire       = mode_req_valid & mode_req_ready;
  assign req_bad        = ({1'b0, mode_req_sel} >= NUM_MODES_L);

`ifdef VTC_VS_WDOG_EN
  localparam int          WW       = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_CYC - 1);
  logic [WW-1:0] wdog;

  // Counts cycles since the last VS rise whenever the generator is running.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          wdog <= '0;
    else if (state == S_HOLD || vs_rise) wdog <= '0;
    else if (wdog != WDOG_LIM)           wdog <= wdog + 1'b1;
  end

  // A VS rise on the limit cycle still counts as a live generator.
  assign wdog_trip = (state != S_HOLD) && !vs_rise && (wdog == WDOG_LIM);
`else
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    vtg_rstn_nxt = vtg_rstn;
    locked_nxt   = locked;
    err_nxt      = 1'b0;
    cur_mode_nxt = cur_mode;
    pending_nxt  = pending;
    load_timing  = 1'b0;

    case (state)
      S_HOLD: begin
        if (cnt == '0) begin
          vtg_rstn_nxt = 1'b1;
          state_nxt    = S_SYNC;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_SYNC: begin
        if (vs_rise) begin
          locked_nxt = 1'b1;
          state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (req_fire) begin
          if (req_bad) begin
            err_nxt = 1'b1;
          end else if (mode_req_sel != cur_mode) begin
            // Old mode stays valid (and locked) until the frame boundary.
            pending_nxt = mode_req_sel;
            state_nxt   = S_WAIT_EOF;
          end
        end
      end
      S_WAIT_EOF: begin
        if (vs_rise) begin
          cur_mode_nxt = pending;
          load_timing  = 1'b1;
          vtg_rstn_nxt = 1'b0;
          locked_nxt   = 1'b0;
          cnt_nxt      = SETTLE_LOAD;
          state_nxt    = S_HOLD;
        end
      end
      default: state_nxt = S_HOLD;
    endcase

    // Lost VS: drop any pending change and restart the generator in cur_mode.
    if (wdog_trip) begin
      err_nxt      = 1'b1;
      locked_nxt   = 1'b0;
      vtg_rstn_nxt = 1'b0;
      cnt_nxt      = SETTLE_LOAD;
      cur_mode_nxt = cur_mode;
      pending_nxt  = cur_mode;
      load_timing  = 1'b0;
      state_nxt    = S_HOLD;
    end

    timing_nxt = load_timing ? rom_timing : timing;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_HOLD;
      cnt       <= SETTLE_LOAD;
      vtg_rstn  <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      cur_mode  <= DEF_MODE_L;
      pending   <= DEF_MODE_L;
      timing    <= mode_timing(DEF_MODE_L);
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      vtg_rstn  <= vtg_rstn_nxt;
      locked    <= locked_nxt;
      err_pulse <= err_nxt;
      cur_mode  <= cur_mode_nxt;
      pending   <= pending_nxt;
      timing    <= timing_nxt;
    end
  end

  assign h_total = X_BITS'(timing.h_total);
  assign h_sync  = X_BITS'(timing.h_sync);
  assign h_bp    = X_BITS'(timing.h_bp);
  assign h_act   = X_BITS'(timing.h_act);
  assign h_fp    = X_BITS'(timing.h_fp);
  assign v_total = Y_BITS'(timing.v_total);
  assign v_sync  = Y_BITS'(timing.v_sync);
  assign v_bp    = Y_BITS'(timing.v_bp);
  assign v_act   = Y_BITS'(timing.v_act);
  assign v_fp    = Y_BITS'(timing.v_fp);

endmodule

// File: tb/tb_vtc_mode_ctrl.sv
// Bench for vtc_mode_ctrl: a default instance (4 modes) and a 3-mode instance
// sharing clock, reset, VS and select. Table-driven mode switches plus
// hand-written sequences for reset, same-mode, invalid, coincident and watchdog cases.
module tb_vtc_mode_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic vs_in = 1'b0;
  logic [1:0] mode_req_sel = 2'd0;
  logic mode_req_valid = 1'b0;
  logic req_valid3 = 1'b0;

  logic mode_req_ready, vtg_rstn, locked, err_pulse;
  logic [11:0] h_total, h_sync, h_bp, h_act, h_fp, v_total, v_sync, v_bp, v_act, v_fp;
  logic [1:0] cur_mode;

  logic ready3, vtg_rstn3, locked3, err3;
  logic [11:0] h_total3, h_sync3, h_bp3, h_act3, h_fp3, v_total3, v_sync3, v_bp3, v_act3, v_fp3;
  logic [1:0] cur_mode3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vtc_mode_ctrl #(.WDOG_CYC(100)) u_dut (
    .clk(clk), .rstn(rstn),
    .mode_req_valid(mode_req_valid), .mode_req_sel(mode_req_sel), .mode_req_ready(mode_req_ready),
    .vs_in(vs_in), .vtg_rstn(vtg_rstn),
    .h_total(h_total), .h_sync(h_sync), .h_bp(h_bp), .h_act(h_act), .h_fp(h_fp),
    .v_total(v_total), .v_sync(v_sync), .v_bp(v_bp), .v_act(v_act), .v_fp(v_fp),
    .cur_mode(cur_mode), .locked(locked), .err_pulse(err_pulse));

  vtc_mode_ctrl #(.NUM_MODES(3), .WDOG_CYC(100)) u_dut3 (
    .clk(clk), .rstn(rstn),
    .mode_req_valid(req_valid3), .mode_req_sel(mode_req_sel), .mode_req_ready(ready3),
    .vs_in(vs_in), .vtg_rstn(vtg_rstn3),
    .h_total(h_total3), .h_sync(h_sync3), .h_bp(h_bp3), .h_act(h_act3), .h_fp(h_fp3),
    .v_total(v_total3), .v_sync(v_sync3), .v_bp(v_bp3), .v_act(v_act3), .v_fp(v_fp3),
    .cur_mode(cur_mode3), .locked(locked3), .err_pulse(err3));

  typedef struct {
    logic [1:0] sel;
    bit         sw;   // 1: real switch, 0: same-mode request dropped
    int         ht, hs, ha, vt, vsy, va;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
  endtask

  // Cycles until vtg_rstn rises, bounded so a stuck DUT still reaches the summary.
  task automatic hold_len(output int n);
    n = 0;
    while (vtg_rstn == 1'b0 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic request(input logic [1:0] s);
    mode_req_sel   = s;
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{2'd1, 1'b1, 1056, 128,  800,  628, 4,  600};
    vecs[1] = '{2'd1, 1'b0, 1056, 128,  800,  628, 4,  600};
    vecs[2] = '{2'd3, 1'b1, 2200, 44,  1920, 1125, 5, 1080};
    vecs[3] = '{2'd0, 1'b1,  800, 96,   640,  525, 2,  480};
    vecs[4] = '{2'd2, 1'b1, 1650, 40,  1280,  750, 5,  720};

    // Reset state
    repeat (3) tick();
    chk("rst_vtg_rstn", int'(vtg_rstn), 0);
    chk("rst_h_total", int'(h_total), 800);
    chk("rst_v_total", int'(v_total), 525);
    chk("rst_cur_mode", int'(cur_mode), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_ready", int'(mode_req_ready), 0);
    chk("rst_err", int'(err_pulse), 0);

    // Release: 16-cycle hold, then lock on the first VS
    rstn = 1'b1;
    hold_len(n);
    chk("init_hold_len", n, 16);
    chk("init_h_total", int'(h_total), 800);
    vs_pulse();
    chk("init_locked", int'(locked), 1);
    chk("init_ready", int'(mode_req_ready), 1);
    chk("init_locked3", int'(locked3), 1);

    // Invalid select on the 3-mode instance
    mode_req_sel = 2'd3;
    req_valid3   = 1'b1;
    tick();
    req_valid3   = 1'b0;
    chk("bad_err", int'(err3), 1);
    chk("bad_ready", int'(ready3), 1);
    chk("bad_cur_mode", int'(cur_mode3), 0);
    chk("bad_locked", int'(locked3), 1);
    tick();
    chk("bad_err_single", int'(err3), 0);
    chk("bad_vtg_rstn", int'(vtg_rstn3), 1);

    // Switch to mode 2 mid-frame, applied only at the next VS rise
    repeat (4) tick();
    mode_req_sel   = 2'd2;
    mode_req_valid = 1'b1;
    #1;
    chk("sw2_ready_before", int'(mode_req_ready), 1);
    tick();
    mode_req_valid = 1'b0;
    chk("sw2_ready_after", int'(mode_req_ready), 0);
    chk("sw2_locked_wait", int'(locked), 1);
    repeat (5) tick();
    chk("sw2_h_total_wait", int'(h_total), 800);
    chk("sw2_cur_mode_wait", int'(cur_mode), 0);
    chk("sw2_vtg_rstn_wait", int'(vtg_rstn), 1);
    vs_pulse();
    chk("sw2_h_total", int'(h_total), 1650);
    chk("sw2_v_total", int'(v_total), 750);
    chk("sw2_cur_mode", int'(cur_mode), 2);
    chk("sw2_vtg_rstn", int'(vtg_rstn), 0);
    chk("sw2_locked", int'(locked), 0);
    hold_len(n);
    chk("sw2_hold_len", n, 16);
    repeat (3) tick();
    chk("sw2_locked_sync", int'(locked), 0);
    vs_pulse();
    chk("sw2_relock", int'(locked), 1);

    // Table-driven switches, including a same-mode request
    for (int i = 0; i < 5; i++) begin
      request(vecs[i].sel);
      chk($sformatf("v%0d_ready", i), int'(mode_req_ready), vecs[i].sw ? 0 : 1);
      chk($sformatf("v%0d_err", i), int'(err_pulse), 0);
      chk($sformatf("v%0d_vtg_rstn_pre", i), int'(vtg_rstn), 1);
      tick();
      tick();
      vs_pulse();
      if (vecs[i].sw) begin
        chk($sformatf("v%0d_vtg_rstn_apply", i), int'(vtg_rstn), 0);
        hold_len(n);
        chk($sformatf("v%0d_hold_len", i), n, 16);
        vs_pulse();
      end else begin
        chk($sformatf("v%0d_vtg_rstn_kept", i), int'(vtg_rstn), 1);
      end
      chk($sformatf("v%0d_cur_mode", i), int'(cur_mode), int'(vecs[i].sel));
      chk($sformatf("v%0d_h_total", i), int'(h_total), vecs[i].ht);
      chk($sformatf("v%0d_h_sync", i), int'(h_sync), vecs[i].hs);
      chk($sformatf("v%0d_h_act", i), int'(h_act), vecs[i].ha);
      chk($sformatf("v%0d_v_total", i), int'(v_total), vecs[i].vt);
      chk($sformatf("v%0d_v_sync", i), int'(v_sync), vecs[i].vsy);
      chk($sformatf("v%0d_v_act", i), int'(v_act), vecs[i].va);
      chk($sformatf("v%0d_h_sum", i), int'(h_sync) + int'(h_bp) + int'(h_act) + int'(h_fp), vecs[i].ht);
      chk($sformatf("v%0d_v_sum", i), int'(v_sync) + int'(v_bp) + int'(v_act) + int'(v_fp), vecs[i].vt);
      chk($sformatf("v%0d_locked", i), int'(locked), 1);
      chk($sformatf("v%0d_ready_run", i), int'(mode_req_ready), 1);
    end

    // Request accepted on the same cycle as a VS rise waits a full frame
    mode_req_sel   = 2'd1;
    mode_req_valid = 1'b1;
    vs_in          = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    vs_in          = 1'b0;
    chk("coin_ready", int'(mode_req_ready), 0);
    chk("coin_vtg_rstn", int'(vtg_rstn), 1);
    chk("coin_cur_mode", int'(cur_mode), 2);
    repeat (3) tick();
    chk("coin_h_total_wait", int'(h_total), 1650);
    chk("coin_vtg_rstn_wait", int'(vtg_rstn), 1);
    vs_pulse();
    chk("coin_cur_mode_apply", int'(cur_mode), 1);
    chk("coin_h_total_apply", int'(h_total), 1056);
    chk("coin_vtg_rstn_apply", int'(vtg_rstn), 0);
    hold_len(n);
    chk("coin_hold_len", n, 16);
    vs_pulse();
    chk("coin_relock", int'(locked), 1);

    // Reset during the hold after a switch to mode 3
    request(2'd3);
    tick();
    tick();
    vs_pulse();
    chk("mrst_h_total_m3", int'(h_total), 2200);
    repeat (3) tick();
    rstn = 1'b0;
    #1;
    chk("mrst_h_total", int'(h_total), 800);
    chk("mrst_v_total", int'(v_total), 525);
    chk("mrst_cur_mode", int'(cur_mode), 0);
    chk("mrst_vtg_rstn", int'(vtg_rstn), 0);
    chk("mrst_locked", int'(locked), 0);
    chk("mrst_ready", int'(mode_req_ready), 0);
    tick();
    tick();
    rstn = 1'b1;
    hold_len(n);
    chk("mrst_hold_len", n, 16);
    vs_pulse();
    chk("mrst_relock", int'(locked), 1);

    // Reset while a change is pending: the pending request is lost
    request(2'd3);
    chk("plost_ready", int'(mode_req_ready), 0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    hold_len(n);
    chk("plost_hold_len", n, 16);
    vs_pulse();
    tick();
    tick();
    vs_pulse();
    chk("plost_cur_mode", int'(cur_mode), 0);
    chk("plost_h_total", int'(h_total), 800);
    chk("plost_vtg_rstn", int'(vtg_rstn), 1);
    chk("plost_locked", int'(locked), 1);

`ifdef VTC_VS_WDOG_EN
    // VS stops in S_RUN: trip 100 cycles after the last rise, then re-apply
    vs_pulse();
    n = 0;
    while (err_pulse == 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk("wdog_trip_cycles", n, 100);
    chk("wdog_locked", int'(locked), 0);
    chk("wdog_vtg_rstn", int'(vtg_rstn), 0);
    chk("wdog_cur_mode", int'(cur_mode), 0);
    tick();
    chk("wdog_err_single", int'(err_pulse), 0);
    hold_len(n);
    chk("wdog_hold_len", n, 15);
    vs_pulse();
    chk("wdog_relock", int'(locked), 1);
    chk("wdog_h_total", int'(h_total), 800);
`else
    // Without the watchdog a missing VS leaves the controller where it is
    repeat (300) tick();
    chk("nowdog_locked", int'(locked), 1);
    chk("nowdog_err", int'(err_pulse), 0);
    chk("nowdog_vtg_rstn", int'(vtg_rstn), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vtc_mode_ctrl.md
Name: vtc_mode_ctrl

Overview:
- Run-time mode controller for the video sync/timing generator.
- Accepts mode-change requests over a valid/ready handshake and defers each change to the next frame boundary, detected on the generator's VS.
- At the boundary it presents the new timing parameter set and holds the generator in reset for a fixed settle window, then releases it and reports lock.
- Sits between the system control logic and the timing generator instance; drives that generator's reset and its timing parameter inputs.

Parameters:
- NUM_MODES, 4, number of entries in the mode table (max 4, indexed by a 2-bit select).
- DEFAULT_MODE, 0, mode applied out of reset.
- X_BITS, 12, width of horizontal timing outputs.
- Y_BITS, 12, width of vertical timing outputs.
- SETTLE_CYC, 16, cycles the generator reset is held low per mode apply (≥2).
- WDOG_CYC, 2000000, VS watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  pixel clock; the same clock as the timing generator.
- rstn  in  1  asynchronous, active-low reset.
- mode_req_valid  in  1  mode change request valid.
- mode_req_sel  in  2  requested mode index.
- mode_req_ready  out  1  controller can accept a request.
- vs_in  in  1  VS from the timing generator, same clock domain, active high.
- vtg_rstn  out  1  registered reset to the timing generator, active low.
- h_total, h_sync, h_bp, h_act, h_fp  out  X_BITS each  current horizontal timing.
- v_total, v_sync, v_bp, v_act, v_fp  out  Y_BITS each  current vertical timing.
- cur_mode  out  2  mode currently applied.
- locked  out  1  generator is running the cur_mode timing.
- err_pulse  out  1  one-cycle pulse on an invalid request (or watchdog trip, if enabled).

Behaviour:
- Reset is asynchronous, active-low.
- Reset values:
  - state = S_HOLD, settle counter = SETTLE_CYC-1.
  - vtg_rstn=0, cur_mode=DEFAULT_MODE, timing outputs = table[DEFAULT_MODE].
  - locked=0, mode_req_ready=0, err_pulse=0, vs_d=0.
- VS edge detection:
  - vs_d registers vs_in.
  - vs_rise = vs_in & ~vs_d.
  - vs_d is forced to 0 while vtg_rstn=0.
- S_HOLD:
  - vtg_rstn=0 for exactly SETTLE_CYC cycles; the counter decrements.
  - At counter==0: vtg_rstn<=1, go to S_SYNC.
- S_SYNC:
  - Wait for the first vs_rise from the restarted generator.
  - On vs_rise: locked<=1, go to S_RUN.
- S_RUN:
  - mode_req_ready=1. A transfer occurs on valid&ready; valid may stay high and be held by the requester.
  - If sel ≥ NUM_MODES: err_pulse=1 next cycle, no state change, ready remains 1.
  - If sel == cur_mode: request is accepted and dropped, no reset, locked stays 1.
  - Otherwise: latch pending<=sel, ready<=0, go to S_WAIT_EOF. locked stays 1, because the old mode is still valid.
- S_WAIT_EOF:
  - On vs_rise, in the same clock edge:
    - cur_mode<=pending, timing outputs <= table[pending].
    - vtg_rstn<=0, locked<=0, counter<=SETTLE_CYC-1, go to S_HOLD.
  - Requests are not accepted (ready=0) in S_HOLD, S_SYNC or S_WAIT_EOF.
- Timing outputs change only on a mode apply, never while vtg_rstn=1.
- Per-mode table entries satisfy total = sync + bp + act + fp, widths 12 bits:
  - 0: 640x480, H 800/96/48/640/16, V 525/2/33/480/10.
  - 1: 800x600, H 1056/128/88/800/40, V 628/4/23/600/1.
  - 2: 1280x720, H 1650/40/220/1280/110, V 750/5/20/720/5.
  - 3: 1920x1080, H 2200/44/148/1920/88, V 1125/5/36/1080/4.
- Simultaneous events: a request accepted on the same cycle as a vs_rise in S_RUN does not apply until the following frame's vs_rise.
- Reset mid-operation: all state is discarded, including any pending request. DEFAULT_MODE is re-applied through S_HOLD/S_SYNC.

Optional Feature:
- Macro: VTC_VS_WDOG_EN.
- When defined:
  - A watchdog counter runs in S_SYNC, S_RUN and S_WAIT_EOF, cleared on every vs_rise.
  - On reaching WDOG_CYC-1: err_pulse=1, locked<=0, pending request discarded.
  - The current mode is re-applied via S_HOLD (vtg_rstn low for SETTLE_CYC cycles), then S_SYNC.
- When undefined: no watchdog logic; a missing VS stalls the FSM in its current state indefinitely.

Decomposition:
- Package vtc_pkg holds:
  - the vtc_timing_t struct (h/v total, sync, bp, act, fp);
  - the 4-entry mode table constant;
  - the state enum (S_HOLD, S_SYNC, S_RUN, S_WAIT_EOF);
  - the mode index constants.
- One sub-module, vtc_mode_rom: combinational index → vtc_timing_t lookup.
- The FSM, counters and edge detect stay in vtc_mode_ctrl.

Test Plan:
- Release rstn → vtg_rstn stays 0 for exactly 16 clk, h_total=800, v_total=525. Model first VS rise 1 clk after release → locked=1, ready=1.
- In S_RUN, request sel=2 mid-frame → ready drops next cycle, timing unchanged until next vs_rise. On that edge: h_total=1650, v_total=750, cur_mode=2, vtg_rstn=0 for 16 clk, locked=0 until the next VS rise.
- Request sel=cur_mode (0) → accepted in 1 cycle, vtg_rstn and locked unchanged, no err_pulse.
- With NUM_MODES=3, request sel=3 → single-cycle err_pulse, cur_mode unchanged, ready stays 1.
- Assert rstn low during S_HOLD after a switch to mode 3 → outputs return to mode 0 immediately, pending request lost, full 16-cycle hold after release.
- VTC_VS_WDOG_EN, WDOG_CYC=100: stop VS in S_RUN → err_pulse at 100 cycles after last vs_rise, locked=0, 16-cycle hold, then relock on the next VS.
